// File: rtl/joy_pkg.sv
// Shared definitions for the joystick direction arbiter.
// Holds the direction bit positions inside a {up,down,left,right} nibble,
// the arbitration-mode and rotation encodings, and two small helpers:
// rotate_dir (remaps a nibble for a rotated cabinet) and hi_bit
// (one-hot of the highest set bit; the tie-break is up > down > left > right).
package joy_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    MODE_LAST  = 2'd0,  // last-pressed 4-way
    MODE_FIRST = 2'd1,  // first-held 4-way
    MODE_8WAY  = 2'd2,  // 8-way, opposite directions cancel
    MODE_RAW   = 2'd3   // no arbitration
  } mode_e;

  typedef enum logic [1:0] {
    ROT_0     = 2'd0,
    ROT_CW90  = 2'd1,
    ROT_180   = 2'd2,
    ROT_CCW90 = 2'd3
  } rot_e;

  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e r);
    logic [3:0] o;
    case (r)
      ROT_CW90:  o = {d[DIR_LEFT], d[DIR_RIGHT], d[DIR_DOWN], d[DIR_UP]};
      ROT_180:   o = {d[DIR_DOWN], d[DIR_UP], d[DIR_RIGHT], d[DIR_LEFT]};
      ROT_CCW90: o = {d[DIR_RIGHT], d[DIR_LEFT], d[DIR_UP], d[DIR_DOWN]};
      default:   o = d;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] hi_bit(input logic [3:0] v);
    logic [3:0] o;
    if (v[DIR_UP])         o = 4'b1000;
    else if (v[DIR_DOWN])  o = 4'b0100;
    else if (v[DIR_LEFT])  o = 4'b0010;
    else if (v[DIR_RIGHT]) o = 4'b0001;
    else                   o = 4'b0000;
    return o;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-bit synchroniser plus debouncer.
// Ports:
//   clk_sys  - system clock, rising edge
//   I_RESETn - asynchronous active-low reset
//   raw      - raw input, asynchronous to clk_sys
//   deb      - debounced, clk_sys-synchronous level
// The debounced value flips only after the synchronised sample has
// disagreed with it on DB_CYCLES+1 consecutive clocks (the counter reaches
// DB_CYCLES, and the next differing sample flips it). DB_CYCLES=0 therefore
// follows the synchronised input with one register of delay, which keeps
// total latency at DB_CYCLES+3 for every setting.
module joy_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_sys,
  input  logic I_RESETn,
  input  logic raw,
  output logic deb
);

  localparam logic [7:0] DB_LIM = 8'(DB_CYCLES);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= 8'd0;
      end else if (cnt == DB_LIM) begin
        deb <= ~deb;
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/joy_dir_arb.sv
// Joystick direction conditioner / arbiter for PLAYERS 4-direction channels.
// Ports:
//   clk_sys  - system clock, rising edge
//   I_RESETn - asynchronous active-low reset
//   dir_in   - raw directions, nibble p at [4p+3:4p], {up,down,left,right}
//   mode     - 0 last-pressed, 1 first-held, 2 8-way cancel, 3 raw
//   rotate   - 0 none, 1 90 CW, 2 180, 3 90 CCW (shared by all players)
//   dir_out  - registered conditioned directions, same bit order
//   dir_chg  - one-cycle strobe per player when its dir_out nibble changes
// Each bit is synchronised and debounced, the nibble is rotated
// combinationally, arbitrated per player and registered once.
module joy_dir_arb
  import joy_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic                   clk_sys,
  input  logic                   I_RESETn,
  input  logic [PLAYERS*4-1:0]   dir_in,
  input  logic [1:0]             mode,
  input  logic [1:0]             rotate,
  output logic [PLAYERS*4-1:0]   dir_out,
  output logic [PLAYERS-1:0]     dir_chg
);

  logic [PLAYERS*4-1:0] deb;
  logic [1:0]           mode_q;
  logic [1:0]           rotate_q;
  logic                 cfg_chg;

  for (genvar gi = 0; gi < PLAYERS*4; gi++) begin : g_deb
    joy_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb (
      .clk_sys  (clk_sys),
      .I_RESETn (I_RESETn),
      .raw      (dir_in[gi]),
      .deb      (deb[gi])
    );
  end

  // A config change blanks every player for one cycle and wipes the
  // edge history, so held bits look freshly pressed afterwards.
  assign cfg_chg = (mode != mode_q) || (rotate != rotate_q);

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      mode_q   <= 2'd0;
      rotate_q <= 2'd0;
    end else begin
      mode_q   <= mode;
      rotate_q <= rotate;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0] rot;
    logic [3:0] prev_rot;
    logic [3:0] rise;
    logic [3:0] mask;
    logic [3:0] mask_nxt;
    logic [3:0] out_q;
    logic [3:0] out_nxt;
    logic       chg_q;

    always_comb begin
      rot      = rotate_dir(deb[4*p +: 4], rot_e'(rotate));
      rise     = rot & ~prev_rot;
      mask_nxt = (rise != 4'd0) ? hi_bit(rise) : mask;
      out_nxt  = 4'd0;
      case (mode)
        MODE_LAST:  out_nxt = rot & mask_nxt;
        MODE_FIRST: begin
          // The registered output doubles as the current selection.
          if (out_q == 4'd0)              out_nxt = hi_bit(rot);
          else if ((rot & out_q) != 4'd0) out_nxt = out_q;
          else                            out_nxt = 4'd0;
        end
        MODE_8WAY: begin
          out_nxt = rot;
          if (rot[DIR_UP] && rot[DIR_DOWN]) begin
            out_nxt[DIR_UP]   = 1'b0;
            out_nxt[DIR_DOWN] = 1'b0;
          end
          if (rot[DIR_LEFT] && rot[DIR_RIGHT]) begin
            out_nxt[DIR_LEFT]  = 1'b0;
            out_nxt[DIR_RIGHT] = 1'b0;
          end
        end
        default:    out_nxt = rot;
      endcase
      if (cfg_chg) out_nxt = 4'd0;
    end

    always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
        prev_rot <= 4'd0;
        mask     <= 4'd0;
        out_q    <= 4'd0;
        chg_q    <= 1'b0;
      end else begin
        if (cfg_chg) begin
          prev_rot <= 4'd0;
          mask     <= 4'd0;
        end else begin
          prev_rot <= rot;
          mask     <= mask_nxt;
        end
        out_q <= out_nxt;
        chg_q <= (out_nxt != out_q);
      end
    end

    assign dir_out[4*p +: 4] = out_q;
    assign dir_chg[p]        = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_arb.sv
// Self-checking bench for joy_dir_arb: directed scenarios plus a long
// randomized run, all checked cycle by cycle against a behavioural model.
module tb_joy_dir_arb;

  localparam int PLAYERS = 2;
  localparam int DB      = 4;
  localparam int NB      = PLAYERS*4;

  logic            clk_sys = 1'b0;
  logic            I_RESETn;
  logic [NB-1:0]   dir_in;
  logic [1:0]      mode;
  logic [1:0]      rotate;
  logic [NB-1:0]   dir_out;
  logic [PLAYERS-1:0] dir_chg;

  always #5 clk_sys = ~clk_sys;

  joy_dir_arb #(.PLAYERS(PLAYERS), .DB_CYCLES(DB)) dut (
    .clk_sys  (clk_sys),
    .I_RESETn (I_RESETn),
    .dir_in   (dir_in),
    .mode     (mode),
    .rotate   (rotate),
    .dir_out  (dir_out),
    .dir_chg  (dir_chg)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a bit is accepted once the last DB+1 synchronised
  // samples all disagree with the accepted value.
  bit           m_s1[NB];
  bit           m_s2[NB];
  bit           m_deb[NB];
  bit           hist[NB][$];
  logic [1:0]   m_mode;
  logic [1:0]   m_rot;
  logic [3:0]   m_prev[PLAYERS];
  int           m_last[PLAYERS];
  logic [NB-1:0] ref_out;
  logic [PLAYERS-1:0] ref_chg;

  function automatic logic [3:0] ref_rotate(input logic [3:0] n, input logic [1:0] r);
    logic u, d, l, rt;
    u = n[3]; d = n[2]; l = n[1]; rt = n[0];
    case (r)
      2'd0:    return n;
      2'd1:    return {l, rt, d, u};
      2'd2:    return {d, u, rt, l};
      default: return {rt, l, u, d};
    endcase
  endfunction

  function automatic int top_idx(input logic [3:0] v);
    for (int b = 3; b >= 0; b--) if (v[b]) return b;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0;
      hist[i].delete();
    end
    for (int p = 0; p < PLAYERS; p++) begin
      m_prev[p] = 4'd0;
      m_last[p] = -1;
    end
    m_mode  = 2'd0;
    m_rot   = 2'd0;
    ref_out = '0;
    ref_chg = '0;
  endtask

  task automatic model_edge();
    bit cfg;
    cfg = (mode != m_mode) || (rotate != m_rot);
    for (int p = 0; p < PLAYERS; p++) begin
      logic [3:0] dn, r, old, nw, rise;
      int t;
      for (int b = 0; b < 4; b++) dn[b] = m_deb[4*p+b];
      r   = ref_rotate(dn, rotate);
      old = ref_out[4*p +: 4];
      nw  = 4'd0;
      if (cfg) begin
        m_last[p] = -1;
        m_prev[p] = 4'd0;
      end else begin
        rise = r & ~m_prev[p];
        if (rise != 4'd0) m_last[p] = top_idx(rise);
        m_prev[p] = r;
        case (mode)
          2'd0: nw = (m_last[p] >= 0 && r[m_last[p]]) ? 4'(1 << m_last[p]) : 4'd0;
          2'd1: begin
            if (old == 4'd0) begin
              t  = top_idx(r);
              nw = (t >= 0) ? 4'(1 << t) : 4'd0;
            end else if ((r & old) != 4'd0) nw = old;
            else nw = 4'd0;
          end
          2'd2: begin
            nw = r;
            if (r[3] && r[2]) nw[3:2] = 2'b00;
            if (r[1] && r[0]) nw[1:0] = 2'b00;
          end
          default: nw = r;
        endcase
      end
      ref_chg[p] = (nw != old);
      ref_out[4*p +: 4] = nw;
    end
    m_mode = mode;
    m_rot  = rotate;
    for (int i = 0; i < NB; i++) begin
      hist[i].push_back(m_s2[i]);
      while (hist[i].size() > DB+1) void'(hist[i].pop_front());
      if (hist[i].size() == DB+1) begin
        bit all_diff = 1;
        for (int k = 0; k < hist[i].size(); k++)
          if (hist[i][k] == m_deb[i]) all_diff = 0;
        if (all_diff) m_deb[i] = ~m_deb[i];
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = dir_in[i];
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    if (I_RESETn) model_edge();
    else model_reset();
    #1;
    chk("dir_out", 32'(dir_out), 32'(ref_out));
    chk("dir_chg", 32'(dir_chg), 32'(ref_chg));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int cycles);
    I_RESETn = 1'b0;
    model_reset();
    #1;
    chk("rst_dir_out", 32'(dir_out), 32'd0);
    chk("rst_dir_chg", 32'(dir_chg), 32'd0);
    run(cycles);
    I_RESETn = 1'b1;
  endtask

  // Counts edges from the first one sampling the new input until bitn rises.
  task automatic measure(input string tag, input int bitn, input int exp_lat);
    int lat = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (lat < 0 && dir_out[bitn]) begin
        lat = k;
        chk({tag, "_strobe"}, 32'(dir_chg[bitn/4]), 32'd1);
      end
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int  hold[PLAYERS];
    int  zeros;
    bit  seen;

    I_RESETn = 1'b0;
    dir_in   = '0;
    mode     = 2'd3;
    rotate   = 2'd0;
    model_reset();
    #2;
    do_reset(3);

    step();
    chk("no_strobe_after_rst", 32'(dir_chg), 32'd0);
    run(5);

    // Raw mode latency on player 0 up.
    dir_in = 8'h08;
    measure("lat_up", 3, DB+3);
    dir_in = 8'h00;
    run(10);

    // Short glitch must not reach the output.
    seen   = 0;
    dir_in = 8'h02;
    for (int k = 0; k < 3; k++) begin step(); if (dir_out != 0) seen = 1; end
    dir_in = 8'h00;
    for (int k = 0; k < 12; k++) begin step(); if (dir_out != 0) seen = 1; end
    chk("glitch", 32'(seen), 32'd0);

    // Last-pressed 4-way.
    mode = 2'd0; run(3);
    dir_in = 8'h08; run(10); chk("m0_up", 32'(dir_out[3:0]), 32'h8);
    dir_in = 8'h09; run(10); chk("m0_add_right", 32'(dir_out[3:0]), 32'h1);
    dir_in = 8'h08; run(10); chk("m0_rel_right", 32'(dir_out[3:0]), 32'h0);

    // First-held 4-way.
    dir_in = 8'h00; run(10);
    mode = 2'd1; run(3);
    dir_in = 8'h02; run(10); chk("m1_left", 32'(dir_out[3:0]), 32'h2);
    dir_in = 8'h0A; run(10); chk("m1_add_up", 32'(dir_out[3:0]), 32'h2);
    dir_in = 8'h08;
    zeros = 0;
    for (int k = 0; k < 12; k++) begin step(); if (dir_out[3:0] == 4'h0) zeros++; end
    chk("m1_gap", 32'(zeros), 32'd1);
    chk("m1_reselect", 32'(dir_out[3:0]), 32'h8);

    // 8-way cancel with 90 CW rotation: U,D,L held -> {U=L,D=R,L=D,R=U}
    // = {1,0,1,1}, left+right cancel -> up only.
    dir_in = 8'h00; run(10);
    mode = 2'd2; rotate = 2'd1; run(3);
    dir_in = 8'h0E; run(10); chk("m2_rot1", 32'(dir_out[3:0]), 32'h8);

    // Reset in the middle of a debounce, input still held afterwards.
    mode = 2'd3; rotate = 2'd0;
    dir_in = 8'h00; run(10);
    dir_in = 8'h08; run(3);
    do_reset(2);
    measure("lat_after_rst", 3, DB+3);

    // Rotation change with up held: one blank cycle, then rotated (right).
    rotate = 2'd1;
    step();
    chk("rot_gap", 32'(dir_out[3:0]), 32'h0);
    chk("rot_gap_strobe", 32'(dir_chg[0]), 32'd1);
    step();
    chk("rot_new", 32'(dir_out[3:0]), 32'h1);

    // Randomized run.
    for (int p = 0; p < PLAYERS; p++) hold[p] = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int p = 0; p < PLAYERS; p++) begin
        hold[p]--;
        if (hold[p] <= 0) begin
          dir_in[4*p +: 4] = 4'($urandom_range(0, 15));
          hold[p] = $urandom_range(1, 12);
        end
      end
      if ($urandom_range(0, 79) == 0) mode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) rotate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 699) == 0) do_reset($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
